// File: rtl/hamming_reg_ctrl.sv
// Sequencing controller for the Hamming-protected multi-mode shift register.
// It accepts one operation at a time over valid/ready and drives the register
// mode/load/enable for the exact cycle count of that operation. Between
// operations it opens periodic scrub windows with enable low, so the register's
// idle correction path can write back corrected data. It counts faulty scrub
// cycles in a saturating counter.
module hamming_reg_ctrl #(
  parameter int WIDTH          = 64,
  parameter int SCRUB_INTERVAL = 256,
  parameter int SCRUB_CYCLES   = 2,
  parameter int CNT_W          = $clog2(WIDTH + 1),
  parameter int ERR_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [CNT_W-1:0] req_count,
  output logic             busy,
  output logic             done,
  output logic             scrub_active,
  output logic [1:0]       reg_mode,
  output logic             reg_load,
  output logic             reg_enable,
  input  logic             reg_fault,
  output logic [ERR_W-1:0] corr_count
);

  localparam int TMR_W = $clog2(SCRUB_INTERVAL);
  localparam int SCW   = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SCRUB_INTERVAL - 1);
  localparam logic [SCW-1:0]   SC_LAST = SCW'(SCRUB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [1:0]       MODE_HOLD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE,
    S_SCRUB
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SCW-1:0]   sc_q, sc_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [ERR_W-1:0] corr_q, corr_d;

  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             scrub_q, scrub_d;
  logic [1:0]       mode_q, mode_d;
  logic             load_q, load_d;
  logic             en_q, en_d;

  // Requests longer than the register are clamped to a full-width shift.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  // Scrub timer stops at the pending value until the scrub window clears it.
  function automatic logic [TMR_W-1:0] tmr_sat_inc(input logic [TMR_W-1:0] t);
    return (t == TMR_MAX) ? t : t + TMR_W'(1);
  endfunction

  // Fault counter sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] e);
    return (&e) ? e : e + ERR_W'(1);
  endfunction

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    corr_d  = corr_q;
    tmr_d   = (state_q == S_SCRUB) ? tmr_q : tmr_sat_inc(tmr_q);

    case (state_q)
      S_IDLE: begin
        // A due scrub wins over a simultaneous request.
        if (tmr_q == TMR_MAX) begin
          state_d = S_SCRUB;
          sc_d    = SC_LAST;
        end else if (req_valid) begin
          op_d  = req_op;
          cnt_d = clamp_count(req_count);
          if (req_op[1])
            state_d = S_LOAD;
          else if (clamp_count(req_count) == '0)
            state_d = S_DONE;
          else
            state_d = S_SHIFT;
        end
      end
      S_LOAD: begin
        if (op_q == 2'b11 || cnt_q == '0)
          state_d = S_DONE;
        else
          state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1))
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_SCRUB: begin
        if (reg_fault)
          corr_d = err_sat_inc(corr_q);
        if (sc_q == '0) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          sc_d = sc_q - SCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    en_d    = (state_d == S_LOAD) || (state_d == S_SHIFT);
    load_d  = (state_d == S_LOAD);
    mode_d  = en_d ? op_d : MODE_HOLD;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    scrub_d = (state_d == S_SCRUB);
    ready_d = (state_d == S_IDLE) && (tmr_d != TMR_MAX);
  end

  // Controller state and registered outputs, all returned to idle values on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      sc_q    <= '0;
      tmr_q   <= '0;
      corr_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scrub_q <= 1'b0;
      mode_q  <= MODE_HOLD;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      tmr_q   <= tmr_d;
      corr_q  <= corr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scrub_q <= scrub_d;
      mode_q  <= mode_d;
      load_q  <= load_d;
      en_q    <= en_d;
    end
  end

  assign req_ready    = ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign scrub_active = scrub_q;
  assign reg_mode     = mode_q;
  assign reg_load     = load_q;
  assign reg_enable   = en_q;
  assign corr_count   = corr_q;

endmodule

// File: tb/tb_hamming_reg_ctrl.sv
// Directed bench for hamming_reg_ctrl: instance A uses the default long scrub
// interval for operation sequencing; instance B uses a 16-cycle interval and a
// 2-bit fault counter for scrub priority and counter saturation.
module tb_hamming_reg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=64, SCRUB_INTERVAL=256, SCRUB_CYCLES=2, ERR_W=16
  logic        a_rst, a_valid, a_ready, a_busy, a_done, a_scrub;
  logic        a_load, a_en, a_fault;
  logic [1:0]  a_op, a_mode;
  logic [6:0]  a_count;
  logic [15:0] a_corr;

  // Instance B: WIDTH=64, SCRUB_INTERVAL=16, SCRUB_CYCLES=2, ERR_W=2
  logic        b_rst, b_valid, b_ready, b_busy, b_done, b_scrub;
  logic        b_load, b_en, b_fault;
  logic [1:0]  b_op, b_mode;
  logic [6:0]  b_count;
  logic [1:0]  b_corr;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  hamming_reg_ctrl #(.WIDTH(64), .SCRUB_INTERVAL(256), .SCRUB_CYCLES(2), .ERR_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
    .req_count(a_count), .busy(a_busy), .done(a_done), .scrub_active(a_scrub),
    .reg_mode(a_mode), .reg_load(a_load), .reg_enable(a_en), .reg_fault(a_fault),
    .corr_count(a_corr)
  );

  hamming_reg_ctrl #(.WIDTH(64), .SCRUB_INTERVAL(16), .SCRUB_CYCLES(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
    .req_count(b_count), .busy(b_busy), .done(b_done), .scrub_active(b_scrub),
    .reg_mode(b_mode), .reg_load(b_load), .reg_enable(b_en), .reg_fault(b_fault),
    .corr_count(b_corr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a request in the current cycle; returns in the cycle after acceptance.
  task automatic a_req(input logic [1:0] op, input logic [6:0] cnt);
    a_valid = 1'b1;
    a_op    = op;
    a_count = cnt;
    chk("a_req_ready", a_ready, 1);
    tick();
    a_valid = 1'b0;
  endtask

  // PISO op: one load cycle, 64 shift cycles, done on the 66th cycle after accept.
  task automatic a_piso_full(input logic [6:0] cnt);
    int bad;
    a_req(2'b10, cnt);
    chk("piso_load", {a_load, a_en, a_mode}, {1'b1, 1'b1, 2'b10});
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (a_en !== 1'b1 || a_load !== 1'b0 || a_mode !== 2'b10 || a_done !== 1'b0) bad++;
    end
    chk("piso_shift_cycles_bad", bad, 0);
    tick();
    chk("piso_done", {a_done, a_en}, {1'b1, 1'b0});
    tick();
    chk("piso_ready_after", {a_ready, a_busy, a_done}, {1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    int bad;
    int pulses;
    a_rst = 1'b1; a_valid = 1'b0; a_op = 2'b00; a_count = '0; a_fault = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_op = 2'b00; b_count = '0; b_fault = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_mode", a_mode, 2'b11);
    chk("rst_ctrl", {a_load, a_en, a_busy, a_done, a_scrub}, 5'b0);
    chk("rst_corr", a_corr, 0);
    chk("rst_ready", a_ready, 1);
    a_rst = 1'b0;

    // PIPO load: load/enable at T+1 only, done at T+2, ready at T+3
    a_req(2'b11, 7'd0);
    chk("pipo_t1", {a_load, a_en, a_mode, a_busy, a_done}, {1'b1, 1'b1, 2'b11, 1'b1, 1'b0});
    tick();
    chk("pipo_t2", {a_load, a_en, a_done}, {1'b0, 1'b0, 1'b1});
    tick();
    chk("pipo_t3", {a_ready, a_busy, a_done}, {1'b1, 1'b0, 1'b0});

    // Shift right by 5: enable T+1..T+5, done at T+6
    a_req(2'b00, 7'd5);
    for (int i = 1; i <= 5; i++) begin
      chk("sr5_drive", {a_en, a_load, a_mode, a_done}, {1'b1, 1'b0, 2'b00, 1'b0});
      if (i < 5) tick();
    end
    tick();
    chk("sr5_done", {a_done, a_en, a_mode}, {1'b1, 1'b0, 2'b11});
    tick();
    chk("sr5_after", {a_done, a_ready}, {1'b0, 1'b1});

    // Shift left with count 0: straight to done at T+1
    a_req(2'b01, 7'd0);
    chk("sl0_done", {a_done, a_en, a_load}, {1'b1, 1'b0, 1'b0});
    tick();

    // PISO full width, then load-only, then clamped count
    a_piso_full(7'd64);
    a_req(2'b10, 7'd0);
    chk("piso0_load", {a_load, a_en, a_mode}, {1'b1, 1'b1, 2'b10});
    tick();
    chk("piso0_done", {a_done, a_en, a_load}, {1'b1, 1'b0, 1'b0});
    tick();
    a_piso_full(7'd100);

    // Reset in the 10th cycle of a 40-cycle shift
    a_req(2'b00, 7'd40);
    for (int i = 0; i < 9; i++) tick();
    chk("rst_mid_en", {a_en, a_busy}, {1'b1, 1'b1});
    a_rst = 1'b1;
    tick();
    chk("rst_mid_after", {a_en, a_busy, a_done, a_mode}, {1'b0, 1'b0, 1'b0, 2'b11});
    chk("rst_mid_corr", a_corr, 0);
    a_rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (a_done === 1'b1 || a_en === 1'b1) pulses++;
    end
    chk("rst_mid_no_done", pulses, 0);

    // Instance B leaves reset: this cycle is c0 with the scrub timer at 0
    b_rst = 1'b0;
    chk("b_rst_state", {b_ready, b_scrub, b_busy, b_corr}, {1'b1, 1'b0, 1'b0, 2'b00});
    for (int i = 0; i < 14; i++) tick();
    chk("b_c14_ready", b_ready, 1);
    tick();
    // c15: scrub pending, request held valid but must not be taken
    chk("b_c15_ready", {b_ready, b_scrub}, {1'b0, 1'b0});
    b_valid = 1'b1; b_op = 2'b11; b_count = '0;
    tick();
    chk("b_c16_scrub", {b_scrub, b_ready, b_en, b_load, b_busy, b_mode}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11});
    tick();
    chk("b_c17_scrub", {b_scrub, b_ready}, {1'b1, 1'b0});
    tick();
    chk("b_c18_idle", {b_scrub, b_ready, b_busy}, {1'b0, 1'b1, 1'b0});
    tick();
    chk("b_c19_load", {b_load, b_en, b_mode}, {1'b1, 1'b1, 2'b11});
    b_valid = 1'b0;
    tick();
    chk("b_c20_done", {b_done, b_corr}, {1'b1, 2'b00});

    // Next scrub at c34/c35; fault flagged on the first cycle only
    for (int i = 0; i < 13; i++) tick();
    chk("b_c33_pending", b_ready, 0);
    tick();
    chk("b_c34_scrub", b_scrub, 1);
    b_fault = 1'b1;
    tick();
    chk("b_c35_corr", b_corr, 1);
    b_fault = 1'b0;
    tick();
    chk("b_c36_corr", {b_scrub, b_corr}, {1'b0, 2'b01});

    // Fault held high while idle is ignored; both scrub cycles then count
    b_fault = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (b_corr !== 2'b01) bad++;
    end
    chk("b_idle_fault_ignored", bad, 0);
    tick();
    tick();
    tick();
    chk("b_c54_corr", b_corr, 3);
    for (int i = 0; i < 16; i++) tick();
    chk("b_c70_scrub", b_scrub, 1);
    tick();
    tick();
    chk("b_c72_sat", {b_scrub, b_corr}, {1'b0, 2'b11});
    b_fault = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
